snitch_clkdiv_prog: RTL



---
 rtl/snitch_clkdiv_prog.sv | 63 ++++++
 1 files changed

// File: rtl/snitch_clkdiv_prog.sv
// snitch_clkdiv_prog: runtime-programmable glitch-free integer clock divider with handshake, enable and bypass
module snitch_clkdiv_prog #(
  parameter int unsigned DivWidth   = 8,
  parameter int unsigned DefaultDiv = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                test_mode_i,
  input  logic                bypass_i,
  input  logic                div_valid_i,
  input  logic [DivWidth-1:0] div_i,
  output logic                div_ready_o,
  output logic [DivWidth-1:0] div_o,
  output logic                running_o,
  output logic                cycle_start_o,
  output logic                clk_o
);
  localparam logic [DivWidth-1:0] One = DivWidth'(1);
  localparam logic [DivWidth-1:0] Two = DivWidth'(2);
  localparam logic [DivWidth-1:0] Def = DivWidth'(DefaultDiv);
  logic [DivWidth-1:0] cnt_q, div_q, pend_div_q, hi, cnt_nxt;
  logic [DivWidth:0]   div_p1;
  logic                pend_q, clk_q, run_q, wrap;
  assign div_p1  = {1'b0, div_q} + {{DivWidth{1'b0}}, 1'b1};
  assign hi      = div_p1[DivWidth:1];
  assign cnt_nxt = cnt_q + One;
  assign wrap    = run_q & (cnt_q == div_q - One);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      div_q      <= Def;
      pend_q     <= 1'b0;
      pend_div_q <= Def;
      clk_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      // ready is ~pend_q, so an accept never collides with an apply below
      if (div_valid_i && !pend_q) begin
        pend_q     <= 1'b1;
        pend_div_q <= (div_i < Two) ? Two : div_i;
      end
      if (!run_q || wrap) begin
        if (pend_q) begin
          div_q  <= pend_div_q;
          pend_q <= 1'b0;
        end
        run_q <= en_i;
        cnt_q <= '0;
        clk_q <= en_i;
      end else begin
        cnt_q <= cnt_nxt;
        clk_q <= cnt_nxt < hi;
      end
    end
  end
  assign div_ready_o   = ~pend_q;
  assign div_o         = div_q;
  assign running_o     = run_q;
  assign cycle_start_o = run_q & (cnt_q == '0);
  // stands in for the tech clock-mux cell; select must be static while running
  assign clk_o = (test_mode_i | bypass_i) ? clk_i : clk_q;
endmodule
